// File: rtl/lnl_mode_sequencer.sv
// Front-panel mode sequencer: debounces four buttons, runs an idle/manual/auto/fault
// state machine and muxes the selected LED pattern generator onto the board LEDs.
module lnl_mode_sequencer #(
    parameter int unsigned BUTTON_COUNT = 4,
    parameter int unsigned LED_COUNT    = 4,
    parameter int unsigned DEBOUNCE     = 16,
    parameter int unsigned DWELL        = 26,
    parameter int unsigned BLINK        = 22
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [BUTTON_COUNT-1:0]           btns,
    input  logic [BUTTON_COUNT*LED_COUNT-1:0] pat_leds,
    output logic [BUTTON_COUNT-1:0]           en,
    output logic [LED_COUNT-1:0]              leds,
    output logic [1:0]                        mode
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StManual = 2'd1,
        StAuto   = 2'd2,
        StFault  = 2'd3
    } state_e;

    localparam logic [DEBOUNCE-1:0]     DbOne    = 1;
    localparam logic [DWELL-1:0]        DwellOne = 1;
    localparam logic [BLINK-1:0]        BlinkOne = 1;
    localparam logic [BUTTON_COUNT-1:0] BtnOne   = 1;

    logic [BUTTON_COUNT-1:0] sync1_q, sync2_q;
    logic [BUTTON_COUNT-1:0] db_q, db_d, press_q, press_d;
    logic [DEBOUNCE-1:0]     db_cnt_q [BUTTON_COUNT];
    logic [DEBOUNCE-1:0]     db_cnt_d [BUTTON_COUNT];

    state_e                  state_q, state_d;
    logic [1:0]              sel_q, sel_d;
    logic [DWELL-1:0]        dwell_q, dwell_d;
    logic [BLINK-1:0]        blink_q, blink_d;
    logic                    phase_q, phase_d;
    logic [BUTTON_COUNT-1:0] en_q, en_d;
    logic [LED_COUNT-1:0]    leds_q, leds_d;
    logic [LED_COUNT-1:0]    slice [BUTTON_COUNT];

    logic                    multi_db;
    logic                    press_any;
    logic [1:0]              press_idx;

    // Counter runs only while the synchronized level disagrees with the debounced one.
    always_comb begin
        db_d    = db_q;
        press_d = '0;
        for (int i = 0; i < BUTTON_COUNT; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (db_cnt_q[i] == {DEBOUNCE{1'b1}}) begin
                    db_d[i]    = ~db_q[i];
                    press_d[i] = ~db_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbOne;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < BUTTON_COUNT; i++) begin
            slice[i] = pat_leds[i*LED_COUNT +: LED_COUNT];
        end
    end

    // Lowest index wins; more than one press at once always coincides with a fault anyway.
    always_comb begin
        press_any = 1'b0;
        press_idx = 2'd0;
        for (int i = BUTTON_COUNT - 1; i >= 0; i--) begin
            if (press_q[i]) begin
                press_any = 1'b1;
                press_idx = 2'(i);
            end
        end
    end

    assign multi_db = |(db_q & (db_q - BtnOne));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        if (multi_db) begin
            state_d = StFault;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (press_any) begin
                        state_d = StManual;
                        sel_d   = press_idx;
                    end
                end
                StManual: begin
                    if (press_any) begin
                        if (press_idx == sel_q) state_d = StAuto;
                        else                    sel_d   = press_idx;
                    end
                end
                StAuto: begin
                    if (press_any) begin
                        state_d = StManual;
                        sel_d   = press_idx;
                    end else if (dwell_q == {DWELL{1'b1}}) begin
                        sel_d = sel_q + 2'd1;
                    end
                end
                StFault: begin
                    if (db_q == '0) begin
                        state_d = StIdle;
                        sel_d   = 2'd0;
                    end
                end
            endcase
        end

        dwell_d = (state_q == StAuto && state_d == StAuto) ? dwell_q + DwellOne : '0;
        blink_d = (state_q == StFault && state_d == StFault) ? blink_q + BlinkOne : '0;
        phase_d = (state_q == StFault && state_d == StFault) ?
                  (phase_q ^ (blink_q == {BLINK{1'b1}})) : 1'b0;

        en_d = '0;
        if (state_d == StManual || state_d == StAuto) en_d[sel_d] = 1'b1;

        // LEDs follow the current state, giving one cycle of latency after en/mode.
        leds_d = '1;
        unique case (state_q)
            StIdle:           leds_d = '1;
            StManual, StAuto: leds_d = slice[sel_q];
            StFault:          leds_d = phase_q ? {(LED_COUNT/2){2'b10}} : {(LED_COUNT/2){2'b01}};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            press_q <= '0;
            for (int i = 0; i < BUTTON_COUNT; i++) db_cnt_q[i] <= '0;
            state_q <= StIdle;
            sel_q   <= 2'd0;
            dwell_q <= '0;
            blink_q <= '0;
            phase_q <= 1'b0;
            en_q    <= '0;
            leds_q  <= '1;
        end else begin
            sync1_q <= btns;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            for (int i = 0; i < BUTTON_COUNT; i++) db_cnt_q[i] <= db_cnt_d[i];
            state_q <= state_d;
            sel_q   <= sel_d;
            dwell_q <= dwell_d;
            blink_q <= blink_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            leds_q  <= leds_d;
        end
    end

    assign en   = en_q;
    assign leds = leds_q;
    assign mode = state_q;

endmodule

// File: tb/tb_lnl_mode_sequencer.sv
// Bench for lnl_mode_sequencer: directed test-plan steps plus random button traffic,
// all compared against an event/time based reference model.
module tb_lnl_mode_sequencer;

    localparam int DB_CYC  = 4;   // 2^DEBOUNCE
    localparam int DW_CYC  = 16;  // 2^DWELL
    localparam int BL_CYC  = 4;   // 2^BLINK

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  btns;
    logic [15:0] pat_leds;
    logic [3:0]  en;
    logic [3:0]  leds;
    logic [1:0]  mode;

    int errors = 0;
    int checks = 0;

    lnl_mode_sequencer #(
        .BUTTON_COUNT(4),
        .LED_COUNT   (4),
        .DEBOUNCE    (2),
        .DWELL       (4),
        .BLINK       (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btns    (btns),
        .pat_leds(pat_leds),
        .en      (en),
        .leds    (leds),
        .mode    (mode)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 idle, 1 manual, 2 auto, 3 fault.
    int         k = 0;
    int         m_state, m_sel, a_edge, a_sel, f_edge;
    int         run [4];
    logic [3:0] m_s1, m_s2, m_db, m_press;
    logic [3:0] e_leds, e_en;
    logic [1:0] e_mode;

    task automatic model_reset();
        m_state = 0; m_sel = 0; a_edge = 0; a_sel = 0; f_edge = 0;
        m_s1 = '0; m_s2 = '0; m_db = '0; m_press = '0;
        for (int i = 0; i < 4; i++) run[i] = 0;
        e_leds = 4'hF; e_en = '0; e_mode = '0;
    endtask

    task automatic model_edge();
        int         ost  = m_state;
        int         osel = m_sel;
        logic [3:0] odb  = m_db;
        logic [3:0] opr  = m_press;
        int         pidx = -1;
        k++;
        for (int i = 0; i < 4; i++) if (opr[i] && pidx < 0) pidx = i;

        case (ost)
            0:       e_leds = 4'hF;
            1, 2:    e_leds = pat_leds[osel*4 +: 4];
            default: e_leds = (((k - f_edge - 1) / BL_CYC) % 2 == 1) ? 4'b1010 : 4'b0101;
        endcase

        if ($countones(odb) >= 2) begin
            if (ost != 3) f_edge = k;
            m_state = 3;
        end else begin
            case (ost)
                0: if (pidx >= 0) begin m_state = 1; m_sel = pidx; end
                1: if (pidx >= 0) begin
                       if (pidx == osel) begin m_state = 2; a_edge = k; a_sel = osel; end
                       else m_sel = pidx;
                   end
                2: if (pidx >= 0) begin m_state = 1; m_sel = pidx; end
                   else m_sel = (a_sel + (k - a_edge) / DW_CYC) % 4;
                default: if (odb == 4'b0) begin m_state = 0; m_sel = 0; end
            endcase
        end
        e_mode = 2'(m_state);
        e_en   = (m_state == 1 || m_state == 2) ? (4'b0001 << m_sel) : 4'b0000;

        m_press = '0;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_db[i]) begin
                run[i]++;
                if (run[i] == DB_CYC) begin
                    m_db[i]    = ~m_db[i];
                    m_press[i] = m_db[i];
                    run[i]     = 0;
                end
            end else begin
                run[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btns;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        @(negedge clk);
        chk("leds", leds, e_leds);
        chk("en", en, e_en);
        chk("mode", {2'b00, mode}, {2'b00, e_mode});
    endtask

    task automatic wait_mode(input logic [1:0] target, input int limit, input string tag);
        for (int n = 0; n < limit && mode !== target; n++) step();
        chk(tag, {2'b00, mode}, {2'b00, target});
    endtask

    initial begin
        rst      = 1'b0;
        btns     = 4'b0000;
        pat_leds = 16'h8421;
        model_reset();
        repeat (3) step();
        chk("reset_leds", leds, 4'b1111);
        rst = 1'b1;

        // Reach MANUAL then reset mid-cycle.
        btns = 4'b0100;
        repeat (10) step();
        chk("t1_manual", {2'b00, mode}, 4'd1);
        #2 rst = 1'b0;
        #1;
        chk("t1_rst_leds", leds, 4'b1111);
        chk("t1_rst_en", en, 4'b0000);
        chk("t1_rst_mode", {2'b00, mode}, 4'd0);
        model_reset();
        btns = 4'b0000;
        repeat (2) step();
        rst = 1'b1;
        repeat (10) step();
        chk("t1_idle", {2'b00, mode}, 4'd0);

        // Short glitch never debounces.
        btns = 4'b0001;
        repeat (3) step();
        btns = 4'b0000;
        repeat (10) step();
        chk("t3_mode", {2'b00, mode}, 4'd0);
        chk("t3_leds", leds, 4'b1111);

        btns = 4'b0100;
        repeat (10) step();
        btns = 4'b0000;
        repeat (10) step();
        chk("t2_mode", {2'b00, mode}, 4'd1);
        chk("t2_en", en, 4'b0100);
        chk("t2_leds", leds, 4'b0100);

        // Manual sel=3, press again for AUTO, watch dwell wraps.
        btns = 4'b1000;
        repeat (10) step();
        btns = 4'b0000;
        repeat (10) step();
        btns = 4'b1000;
        wait_mode(2'd2, 20, "t4_auto_wait");
        chk("t4_en_start", en, 4'b1000);
        btns = 4'b0000;
        repeat (16) step();
        chk("t4_en_wrap", en, 4'b0001);
        repeat (16) step();
        chk("t4_en_next", en, 4'b0010);

        btns = 4'b0010;
        wait_mode(2'd1, 20, "t5_manual_wait");
        chk("t5_en", en, 4'b0010);
        btns = 4'b0000;
        repeat (40) step();
        chk("t5_en_hold", en, 4'b0010);
        chk("t5_mode_hold", {2'b00, mode}, 4'd1);

        // Two buttons -> FAULT blink, release -> IDLE.
        btns = 4'b0011;
        wait_mode(2'd3, 20, "t6_fault_wait");
        chk("t6_en", en, 4'b0000);
        step();
        chk("t6_blink0", leds, 4'b0101);
        repeat (4) step();
        chk("t6_blink1", leds, 4'b1010);
        repeat (4) step();
        chk("t6_blink2", leds, 4'b0101);
        btns = 4'b0000;
        wait_mode(2'd0, 20, "t6_idle_wait");
        step();
        chk("t6_idle_leds", leds, 4'b1111);

        // Random traffic against the model.
        for (int s = 0; s < 80; s++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)      btns = 4'b0000;
            else if (r < 8) btns = 4'b0001 << $urandom_range(0, 3);
            else            btns = 4'($urandom_range(0, 15));
            pat_leds = 16'($urandom);
            if ($urandom_range(0, 5) == 0) repeat (int'($urandom_range(15, 45))) step();
            else                           repeat (int'($urandom_range(1, 14))) step();
        end
        btns = 4'b0000;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
